// File: rtl/sobel_scan_ctrl_if.sv
// Control/data bundle between the Sobel frame sequencer and its ROM, window, sobel and frame-buffer neighbours.
// master = sequencer side, slave = environment side.
interface sobel_scan_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic              start;
  logic              busy;
  logic              done;
  logic [7:0]        frame_cnt;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic              win_shift;
  logic              win_valid;
  logic              sob_data;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_wdata;

  modport master (
    input  start, sob_data,
    output busy, done, frame_cnt, rom_en, rom_addr, win_shift, win_valid,
           fb_we, fb_addr, fb_wdata
  );

  modport slave (
    output start, sob_data,
    input  busy, done, frame_cnt, rom_en, rom_addr, win_shift, win_valid,
           fb_we, fb_addr, fb_wdata
  );
endinterface

// File: rtl/sobel_scan_ctrl.sv
// Frame sequencer: raster-scans the image ROM, drives the 3x3 window shift/valid,
// and writes delayed sobel results for interior pixels into the frame buffer.
module sobel_scan_ctrl #(
  parameter int IMG_W    = 128,
  parameter int IMG_H    = 96,
  parameter int ADDR_W   = 14,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  sobel_scan_ctrl_if.master io
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] CTR_OFS   = ADDR_W'(IMG_W + 1);
  localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 1);
  localparam logic [DW-1:0]     DRAIN_END = DW'(PIPE_LAT);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic              rom_en_q, rom_en_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic              win_shift_q;
  logic              win_valid_q;
  logic [ADDR_W-1:0] sh_addr_q;
  logic [ADDR_W-1:0] ctr_addr;

  logic [PIPE_LAT-1:0] vld_pipe_q;
  logic [ADDR_W-1:0]   addr_pipe_q [PIPE_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      col_q       <= '0;
      row_q       <= '0;
      drain_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      col_q       <= col_d;
      row_q       <= row_d;
      drain_q     <= drain_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Row/col track rom_addr so the window test needs no divide or multiply.
  always_comb begin
    state_d     = state_q;
    rom_en_d    = 1'b0;
    rom_addr_d  = '0;
    col_d       = '0;
    row_d       = '0;
    drain_d     = '0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          state_d  = SCAN;
          rom_en_d = 1'b1;
        end
      end
      SCAN: begin
        if (rom_addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          rom_en_d   = 1'b1;
          rom_addr_d = rom_addr_q + 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
            row_d = row_q;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_END) state_d = DONE;
        else                      drain_d = drain_q + 1'b1;
      end
      DONE: begin
        state_d     = IDLE;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_shift_q <= 1'b0;
      win_valid_q <= 1'b0;
      sh_addr_q   <= '0;
    end else begin
      win_shift_q <= rom_en_q;
      win_valid_q <= rom_en_q && (row_q >= RW'(2)) && (col_q >= CW'(2));
      sh_addr_q   <= rom_addr_q;
    end
  end

  assign ctr_addr = sh_addr_q - CTR_OFS;

  // Address is zeroed on invalid slots so fb_addr only ever shows real centres.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) addr_pipe_q[i] <= '0;
    end else begin
      vld_pipe_q[0]  <= win_valid_q;
      addr_pipe_q[0] <= win_valid_q ? ctr_addr : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        addr_pipe_q[i] <= addr_pipe_q[i-1];
      end
    end
  end

  assign io.busy      = (state_q == SCAN) || (state_q == DRAIN);
  assign io.done      = (state_q == DONE);
  assign io.frame_cnt = frame_cnt_q;
  assign io.rom_en    = rom_en_q;
  assign io.rom_addr  = rom_addr_q;
  assign io.win_shift = win_shift_q;
  assign io.win_valid = win_valid_q;
  assign io.fb_we     = vld_pipe_q[PIPE_LAT-1];
  assign io.fb_addr   = addr_pipe_q[PIPE_LAT-1];
  assign io.fb_wdata  = io.sob_data & vld_pipe_q[PIPE_LAT-1];

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Bench for sobel_scan_ctrl: 8x6 image instance with scoreboard and timing table,
// plus a default-parameter instance for the full-size pass.
module tb_sobel_scan_ctrl;
  localparam int W = 8, H = 6, PL = 2, AW = 6, N = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_scan_ctrl_if #(.ADDR_W(AW)) b ();
  sobel_scan_ctrl_if #(.ADDR_W(14)) b2 ();

  assign b.sob_data  = b.fb_addr[0];
  assign b2.sob_data = b2.fb_addr[0];

  sobel_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .io(b.master)
  );
  sobel_scan_ctrl dut2 (
    .clk(clk), .rst(rst), .io(b2.master)
  );

  int errs = 0, checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_q[$];
  int t0, nwr, first_we, last_we, exp_fc;
  bit done_seen;
  int nw2, first_addr2, prev_addr2, ord_err2;
  bit done2_seen;
  int done2_cyc;

  typedef struct {
    int   k;
    logic rom_en;
    logic [AW-1:0] rom_addr;
    logic win_shift;
    logic win_valid;
    logic busy;
    logic done;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [26:0] outs();
    return {b.busy, b.done, b.frame_cnt, b.rom_en, b.rom_addr, b.win_shift,
            b.win_valid, b.fb_we, b.fb_addr, b.fb_wdata};
  endfunction

  task automatic push_frame();
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++) exp_q.push_back(r * W + c);
  endtask

  // Scoreboard side: every write is matched against the expected centre order.
  always @(negedge clk) begin
    if (!rst) begin
      if (b.fb_we) begin
        nwr++;
        if (first_we < 0) first_we = cyc - t0;
        last_we = cyc - t0;
        checks++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL extra_write: got addr %0d expected no write", b.fb_addr);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (b.fb_addr != AW'(e) || b.fb_wdata != e[0]) begin
            errs++;
            $display("FAIL write: got addr %0d data %0d expected addr %0d data %0d",
                     b.fb_addr, b.fb_wdata, e, e[0]);
          end
        end
      end
      if (b.done) done_seen = 1'b1;
      if (b2.fb_we) begin
        if (nw2 == 0) first_addr2 = b2.fb_addr;
        else if (int'(b2.fb_addr) <= prev_addr2) ord_err2++;
        prev_addr2 = b2.fb_addr;
        nw2++;
      end
      if (b2.done && !done2_seen) begin
        done2_seen = 1'b1;
        done2_cyc  = cyc;
      end
    end
  end

  task automatic begin_pass();
    push_frame();
    b.start   = 1'b1;
    t0        = cyc;
    done_seen = 1'b0;
    first_we  = -1;
    nwr       = 0;
    tick();
    b.start = 1'b0;
  endtask

  task automatic finish_pass(input bit full);
    for (int i = 0; i < 200 && !done_seen; i++) tick();
    chk("done_seen", done_seen, 1);
    if (full) begin
      chk("done_time", cyc - t0, N + 2 + PL);
      chk("first_we_time", first_we, 22);
      chk("last_we_time", last_we, N + 1 + PL);
      chk("write_count", nwr, (W - 2) * (H - 2));
    end
    tick();
    exp_fc = (exp_fc + 1) % 256;
    chk("frame_cnt", b.frame_cnt, exp_fc);
    if (full) chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int d, nwr_rst;
    tbl[0] = '{1,  1'b1, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{2,  1'b1, 6'd1,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{10, 1'b1, 6'd9,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{19, 1'b1, 6'd18, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{20, 1'b1, 6'd19, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{48, 1'b1, 6'd47, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{49, 1'b0, 6'd0,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{50, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{51, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{52, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1};

    b.start = 1'b0; b2.start = 1'b0;
    nwr = 0; first_we = -1; t0 = 0; exp_fc = 0; done_seen = 1'b0;
    nw2 = 0; first_addr2 = -1; prev_addr2 = -1; ord_err2 = 0;
    done2_seen = 1'b0; done2_cyc = 0;
    repeat (3) tick();
    chk("reset_outputs", outs(), 0);
    rst = 1'b0;
    tick();
    chk("idle_outputs", outs(), 0);

    // Single pass against the timing table.
    begin_pass();
    for (int i = 0; i < 10; i++) begin
      while (cyc - t0 < tbl[i].k) tick();
      chk($sformatf("table_k%0d", tbl[i].k),
          {tbl[i].rom_en ? b.rom_addr : 6'd0, b.rom_en, b.win_shift, b.win_valid, b.busy, b.done},
          {tbl[i].rom_addr, tbl[i].rom_en, tbl[i].win_shift, tbl[i].win_valid, tbl[i].busy, tbl[i].done});
    end
    finish_pass(1'b1);

    // start held high: back-to-back passes.
    push_frame(); push_frame();
    b.start = 1'b1; t0 = cyc; done_seen = 1'b0; nwr = 0;
    for (int i = 0; i < 200 && !done_seen; i++) tick();
    chk("held_done1_time", cyc - t0, N + 2 + PL);
    d = cyc; done_seen = 1'b0; t0 = d + 1;
    for (int i = 0; i < 5 && !b.rom_en; i++) tick();
    chk("held_restart_gap", cyc - d, 2);
    b.start = 1'b0;
    for (int i = 0; i < 200 && !done_seen; i++) tick();
    chk("held_done2_time", cyc - t0, N + 2 + PL);
    repeat (4) tick();
    exp_fc = (exp_fc + 2) % 256;
    chk("held_frame_cnt", b.frame_cnt, exp_fc);
    chk("held_write_count", nwr, 2 * (W - 2) * (H - 2));
    chk("held_queue_empty", exp_q.size(), 0);
    chk("held_idle_busy", b.busy, 0);

    // Reset in the middle of SCAN.
    begin_pass();
    while (cyc - t0 < 30) tick();
    #1 rst = 1'b1;
    #1 chk("midscan_reset_outputs", outs(), 0);
    exp_q.delete();
    exp_fc = 0;
    nwr_rst = nwr;
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("no_we_after_reset", nwr, nwr_rst);
    chk("frame_cnt_after_reset", b.frame_cnt, 0);
    begin_pass();
    finish_pass(1'b1);

    // Run up to frame_cnt=255, then wrap.
    for (int p = 0; p < 254; p++) begin
      begin_pass();
      finish_pass(1'b0);
    end
    chk("frame_cnt_255", b.frame_cnt, 255);
    begin_pass();
    finish_pass(1'b1);
    chk("frame_cnt_wrap", b.frame_cnt, 0);

    // Full-size default-parameter pass.
    b2.start = 1'b1;
    d = cyc;
    tick();
    b2.start = 1'b0;
    for (int i = 0; i < 13000 && !done2_seen; i++) tick();
    chk("big_done_seen", done2_seen, 1);
    chk("big_done_time", done2_cyc - d, 12292);
    chk("big_write_count", nw2, 11844);
    chk("big_first_addr", first_addr2, 129);
    chk("big_order_errors", ord_err2, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
